memory: RTL

MEMORY -- requirements
Module: memory

---
 rtl/common.sv | 52 +++++
 rtl/memory_align.sv | 47 ++++
 rtl/memory.sv | 85 ++++++++
 3 files changed

// File: rtl/common.sv
// Shared types for the memory stage: FSM states, writeback-source select,
// execute-to-memory request bundle and the writeback bundle.
package common;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mem_state_t;

  typedef enum logic [1:0] {
    STRD_ALU,
    STRD_MEM_DATA,
    STRD_PC4,
    STRD_IMM
  } st_rd_t;

  typedef struct packed {
    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] data_addr;
  } mem_t;

  typedef struct packed {
    logic            reg_write;
    st_rd_t          st_rd;
    logic [4:0]      rd;
    logic [XLEN-1:0] write_data;
  } wri_t;

  localparam wri_t WRI_BUBBLE = '{reg_write: 1'b0, st_rd: STRD_ALU, rd: 5'd0, write_data: '0};

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/memory_align.sv
// Byte-lane steering: store strobe/data alignment and load lane extraction
// with sign/zero extension. Purely combinational.
module mem_align
  import common::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      fun3,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] store_in,
  input  logic [XLEN-1:0] load_raw,
  output logic [7:0]      strobe,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] lane;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;
  logic signed [31:0] lane_w;

  assign shamt = {offset, 3'b000};

  // Bits shifted past byte 7 are dropped; misaligned accesses simply lose them.
  assign strobe     = size_mask(fun3[1:0]) << offset;
  assign store_data = store_in << shamt;
  assign lane       = load_raw >> shamt;

  assign lane_b = lane[7:0];
  assign lane_h = lane[15:0];
  assign lane_w = lane[31:0];

  always_comb begin
    load_data = lane;
    case (fun3)
      F3_B:    load_data = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_H:    load_data = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_W:    load_data = {{(XLEN-32){lane_w[31]}}, lane_w};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, lane[15:0]};
      F3_WU:   load_data = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/memory.sv
// Pipeline memory stage: issues one data-bus request per load/store, holds it
// until the response strobe, and hands the writeback bundle on at update.
module memory
  import common::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  mem_t            mem_now,
  input  wri_t            wri_now,
  input  logic [2:0]      mem_fun3,
  input  logic            mem_nop,
  input  logic [XLEN-1:0] mem_pc,
  input  logic            update,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            finished,
  output wri_t            wri_nxt,
  output logic [XLEN-1:0] wri_pc
);

  mem_state_t      state;
  logic [XLEN-1:0] rdata_q;
  logic            access;
  logic [7:0]      strobe;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] load_data;

  mem_align #(.XLEN(XLEN)) u_align (
    .fun3      (mem_fun3),
    .offset    (mem_now.data_addr[2:0]),
    .store_in  (mem_now.write_data),
    .load_raw  (dresp_data),
    .strobe    (strobe),
    .store_data(store_data),
    .load_data (load_data)
  );

  assign access = !mem_nop && (mem_now.mem_read || mem_now.mem_write);

  // The request is presented straight out of IDLE so a fresh access goes on
  // the bus in the first cycle after update; mem_now stays stable until then.
  assign dreq_valid  = (state == WAIT) || (state == IDLE && access);
  assign dreq_addr   = mem_now.data_addr;
  assign dreq_size   = {1'b0, mem_fun3[1:0]};
  assign dreq_strobe = mem_now.mem_write ? strobe : 8'h00;
  assign dreq_data   = store_data;
  assign finished    = (state == DONE) || (state == IDLE && !access);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rdata_q <= '0;
      wri_nxt <= WRI_BUBBLE;
      wri_pc  <= '0;
    end else begin
      case (state)
        IDLE:    if (access) state <= dresp_ok ? DONE : WAIT;
        WAIT:    if (dresp_ok) state <= DONE;
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase

      if (dreq_valid && dresp_ok) rdata_q <= load_data;

      if (update) begin
        state <= IDLE;
        if (mem_nop) begin
          wri_nxt <= WRI_BUBBLE;
        end else begin
          wri_nxt <= wri_now;
          wri_pc  <= mem_pc;
          if (wri_now.st_rd == STRD_MEM_DATA) wri_nxt.write_data <= rdata_q;
        end
      end
    end
  end

endmodule
